vga_text_engine: RTL and testbench



---
 rtl/vga_text_engine_if.sv | 29 ++
 rtl/vga_text_engine.sv | 150 +++++++++++++++
 tb/tb_vga_text_engine.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_text_engine_if.sv
// Memory-side bus of the text engine: text RAM and font ROM read ports.
interface vga_text_engine_if #(
  parameter int unsigned COLS   = 80,
  parameter int unsigned ROWS   = 34,
  parameter int unsigned CHAR_W = 8,
  parameter int unsigned CHAR_H = 14
);
  localparam int unsigned AW  = $clog2(COLS * ROWS);
  localparam int unsigned FAW = 8 + $clog2(CHAR_W);

  logic [AW-1:0]     char_address;
  logic [15:0]       char_data;
  logic [FAW-1:0]    font_address;
  logic [CHAR_H-1:0] font_data;

  modport master (
    output char_address,
    output font_address,
    input  char_data,
    input  font_data
  );

  modport slave (
    input  char_address,
    input  font_address,
    output char_data,
    output font_data
  );
endinterface

// File: rtl/vga_text_engine.sv
// Text-mode pixel engine: coordinates -> text/font addresses -> 8-bit color.
// Five-stage pipeline, one pixel per clock, no stalls.
module vga_text_engine #(
  parameter int unsigned COLS         = 80,
  parameter int unsigned ROWS         = 34,
  parameter int unsigned CHAR_W       = 8,
  parameter int unsigned CHAR_H       = 14,
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic                     clk25mhz,
  input  logic                     reset_n,
  input  logic [9:0]               hindex,
  input  logic [9:0]               vindex,
  input  logic                     cursor_en,
  input  logic [7:0]               cursor_col,
  input  logic [5:0]               cursor_row,
  output logic [7:0]               color,
  vga_text_engine_if.master        mem
);

  localparam int unsigned AW       = $clog2(COLS * ROWS);
  localparam int unsigned CW       = $clog2(CHAR_W);
  localparam int unsigned FAW      = 8 + CW;
  localparam int unsigned GRW      = (CHAR_H > 1) ? $clog2(CHAR_H) : 1;
  localparam int unsigned TRW      = 10;
  localparam int unsigned RBW      = 20;
  localparam int unsigned FCW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned LINE_PIX = COLS * CHAR_W;

  logic [GRW-1:0] glyph_row;
  logic [TRW-1:0] text_row;
  logic [RBW-1:0] row_base;
  logic [FCW-1:0] frame_cnt;
  logic           blink_phase;

  logic [9:0]     col_c;
  logic [CW-1:0]  gcol_c;
  logic           valid_c;
  logic           hit_c;

  logic [CW-1:0]  s1_gcol, s2_gcol;
  logic [GRW-1:0] s1_grow, s2_grow, s3_grow, s4_grow;
  logic           s1_valid, s2_valid, s3_valid, s4_valid;
  logic           s1_hit, s2_hit;
  logic [3:0]     s3_fg, s3_bg, s4_fg, s4_bg;
  logic [3:0]     pix_c;

  // Map a 4-bit attribute to the DAC bit layout.
  function automatic logic [7:0] map_color(input logic [3:0] pix);
    logic [2:0] dark;
    logic [2:0] bright;
    dark   = pix[2:0];
    bright = pix[3] ? ((pix[2:0] == 3'b000) ? 3'b111 : pix[2:0]) : 3'b000;
    return {dark[2], bright[2], 1'b0, dark[1], bright[1], 1'b0, dark[0], bright[0]};
  endfunction

  // Current cell, validity and cursor hit for the presented pixel.
  always_comb begin
    col_c   = hindex >> CW;
    gcol_c  = hindex[CW-1:0];
    valid_c = (32'(hindex) < LINE_PIX) && (32'(vindex) < V_ACTIVE) &&
              (32'(text_row) < ROWS);
    hit_c   = cursor_en && blink_phase &&
              (col_c == 10'(cursor_col)) &&
              (text_row == TRW'(cursor_row)) &&
              ((32'(glyph_row) + 32'd2) >= CHAR_H);
  end

  // Vertical counters advance at end of each active line, clear in vertical blank.
  always_ff @(posedge clk25mhz or negedge reset_n) begin
    if (!reset_n) begin
      glyph_row <= '0;
      text_row  <= '0;
      row_base  <= '0;
    end else if (32'(hindex) == H_ACTIVE) begin
      if (32'(vindex) >= V_ACTIVE) begin
        glyph_row <= '0;
        text_row  <= '0;
        row_base  <= '0;
      end else if (32'(glyph_row) == CHAR_H - 1) begin
        glyph_row <= '0;
        text_row  <= text_row + TRW'(1);
        row_base  <= row_base + RBW'(COLS);
      end else begin
        glyph_row <= glyph_row + GRW'(1);
      end
    end
  end

  // Frame counter drives the cursor blink phase.
  always_ff @(posedge clk25mhz or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (hindex == 10'd0 && 32'(vindex) == V_ACTIVE) begin
      if (32'(frame_cnt) == BLINK_FRAMES - 1) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + FCW'(1);
      end
    end
  end

  // Pixel value from the font bit, selecting foreground or background.
  always_comb begin
    pix_c = mem.font_data[s4_grow] ? s4_fg : s4_bg;
  end

  // Pipeline: address issue, RAM wait, attribute capture, ROM wait, color.
  always_ff @(posedge clk25mhz or negedge reset_n) begin
    if (!reset_n) begin
      mem.char_address <= '0;
      mem.font_address <= '0;
      color            <= '0;
      s1_gcol  <= '0;  s2_gcol  <= '0;
      s1_grow  <= '0;  s2_grow  <= '0;  s3_grow <= '0;  s4_grow <= '0;
      s1_valid <= 1'b0; s2_valid <= 1'b0; s3_valid <= 1'b0; s4_valid <= 1'b0;
      s1_hit   <= 1'b0; s2_hit   <= 1'b0;
      s3_fg    <= '0;  s3_bg    <= '0;  s4_fg   <= '0;  s4_bg   <= '0;
    end else begin
      mem.char_address <= AW'(row_base + RBW'(col_c));
      s1_gcol  <= gcol_c;
      s1_grow  <= glyph_row;
      s1_valid <= valid_c;
      s1_hit   <= hit_c;

      s2_gcol  <= s1_gcol;
      s2_grow  <= s1_grow;
      s2_valid <= s1_valid;
      s2_hit   <= s1_hit;

      mem.font_address <= FAW'({mem.char_data[7:0], s2_gcol});
      s3_fg    <= s2_hit ? mem.char_data[15:12] : mem.char_data[11:8];
      s3_bg    <= s2_hit ? mem.char_data[11:8]  : mem.char_data[15:12];
      s3_grow  <= s2_grow;
      s3_valid <= s2_valid;

      s4_fg    <= s3_fg;
      s4_bg    <= s3_bg;
      s4_grow  <= s3_grow;
      s4_valid <= s3_valid;

      color <= s4_valid ? map_color(pix_c) : 8'h00;
    end
  end

endmodule

// File: tb/tb_vga_text_engine.sv
// Directed bench for vga_text_engine: address walk, colors, blanking,
// cursor blink, small-geometry instance and asynchronous reset.
module tb_vga_text_engine;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] hindex, vindex;
  logic       cursor_en;
  logic [7:0] cursor_col;
  logic [5:0] cursor_row;
  logic [7:0] color;
  logic [7:0] s_color;

  logic [15:0] tword;
  logic [13:0] fbits;
  logic [7:0]  col_mask;

  int n_tests = 0;
  int n_fail  = 0;

  always #20 clk = ~clk;

  vga_text_engine_if #(.COLS(80), .ROWS(34), .CHAR_W(8), .CHAR_H(14)) mif ();
  vga_text_engine_if #(.COLS(40), .ROWS(30), .CHAR_W(4), .CHAR_H(8))  sif ();

  vga_text_engine dut (
    .clk25mhz(clk), .reset_n(reset_n), .hindex(hindex), .vindex(vindex),
    .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
    .color(color), .mem(mif)
  );

  vga_text_engine #(.COLS(40), .ROWS(30), .CHAR_W(4), .CHAR_H(8)) dut_s (
    .clk25mhz(clk), .reset_n(reset_n), .hindex(hindex), .vindex(vindex),
    .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
    .color(s_color), .mem(sif)
  );

  // Registered text RAM / font ROM models (one-cycle read latency).
  always @(posedge clk) begin
    mif.char_data <= tword;
    mif.font_data <= col_mask[mif.font_address[2:0]] ? fbits : 14'h0;
    sif.char_data <= tword;
    sif.font_data <= 8'h00;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int h, input int v);
    hindex = 10'(h);
    vindex = 10'(v);
    @(posedge clk);
    #1;
  endtask

  // Blanking clear, then line ends up to the start of line v.
  task automatic goto_line(input int v);
    step(640, 480);
    for (int l = 0; l < v; l++) step(640, l);
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) begin
      step(0, 480);
      step(1, 480);
    end
  endtask

  task automatic pix_check(input string name, input int v, input int h, input logic [7:0] exp);
    goto_line(v);
    for (int k = 0; k < 5; k++) step(h, v);
    check(name, 32'(color), 32'(exp));
  endtask

  typedef struct {
    int          v;
    int          h;
    logic [15:0] word;
    logic [13:0] fb;
    bit          chk_addr;
    int          exp_addr;
    logic [7:0]  exp_color;
  } vec_t;

  vec_t vecs[16];

  initial begin
    vecs[0]  = '{1,   0,   16'h1F41, 14'h0002, 1'b1, 0,    8'hDB};
    vecs[1]  = '{1,   5,   16'h1F41, 14'h0000, 1'b1, 0,    8'h02};
    vecs[2]  = '{1,   9,   16'h1841, 14'h0002, 1'b1, 1,    8'h49};
    vecs[3]  = '{0,   15,  16'h1F41, 14'h0001, 1'b1, 1,    8'hDB};
    vecs[4]  = '{14,  0,   16'h1F41, 14'h0001, 1'b1, 80,   8'hDB};
    vecs[5]  = '{475, 639, 16'h1F41, 14'h2000, 1'b1, 2719, 8'hDB};
    vecs[6]  = '{475, 639, 16'h1F41, 14'h1FFF, 1'b1, 2719, 8'h02};
    vecs[7]  = '{100, 200, 16'hC000, 14'h0000, 1'b1, 585,  8'hC0};
    vecs[8]  = '{50,  320, 16'h0700, 14'h0100, 1'b1, 280,  8'h92};
    vecs[9]  = '{27,  631, 16'h0A00, 14'h2000, 1'b1, 158,  8'h18};
    vecs[10] = '{476, 0,   16'h1F41, 14'h3FFF, 1'b0, 0,    8'h00};
    vecs[11] = '{479, 100, 16'h1F41, 14'h3FFF, 1'b0, 0,    8'h00};
    vecs[12] = '{10,  640, 16'h1F41, 14'h3FFF, 1'b0, 0,    8'h00};
    vecs[13] = '{10,  700, 16'h1F41, 14'h3FFF, 1'b0, 0,    8'h00};
    vecs[14] = '{480, 5,   16'h1F41, 14'h3FFF, 1'b0, 0,    8'h00};
    vecs[15] = '{500, 300, 16'h1F41, 14'h3FFF, 1'b0, 0,    8'h00};

    reset_n    = 1'b0;
    hindex     = 10'd640;
    vindex     = 10'd481;
    cursor_en  = 1'b0;
    cursor_col = 8'd3;
    cursor_row = 6'd2;
    tword      = 16'h1F41;
    fbits      = 14'h0001;
    col_mask   = 8'b0000_0100;

    #50;
    check("reset char_address", 32'(mif.char_address), 0);
    check("reset font_address", 32'(mif.font_address), 0);
    check("reset color", 32'(color), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Address walk and pipeline latency on line 0, only glyph column 2 lit.
    goto_line(0);
    for (int i = 0; i < 20; i++) begin
      int h;
      step(i, 0);
      if (i < 16) check($sformatf("walk addr h=%0d", i), 32'(mif.char_address), 32'(i / 8));
      if (i >= 2) begin
        h = i - 2;
        check($sformatf("font_address h=%0d", h), 32'(mif.font_address),
              (32'(tword[7:0]) << 3) | 32'(h % 8));
      end
      if (i >= 4) begin
        h = i - 4;
        check($sformatf("latency color h=%0d", h), 32'(color),
              ((h % 8) == 2) ? 32'h0000_00DB : 32'h0000_0002);
      end
    end

    // Table of single-pixel vectors.
    col_mask = 8'hFF;
    for (int n = 0; n < 16; n++) begin
      tword = vecs[n].word;
      fbits = vecs[n].fb;
      goto_line(vecs[n].v);
      step(vecs[n].h, vecs[n].v);
      if (vecs[n].chk_addr)
        check($sformatf("vec%0d char_address", n), 32'(mif.char_address), 32'(vecs[n].exp_addr));
      step(vecs[n].h, vecs[n].v);
      step(vecs[n].h, vecs[n].v);
      if (vecs[n].chk_addr)
        check($sformatf("vec%0d font_address", n), 32'(mif.font_address),
              (32'(vecs[n].word[7:0]) << 3) | 32'(vecs[n].h % 8));
      step(vecs[n].h, vecs[n].v);
      step(vecs[n].h, vecs[n].v);
      check($sformatf("vec%0d color", n), 32'(color), 32'(vecs[n].exp_color));
    end

    // Small geometry: 40x30 cells of 4x8 pixels.
    tword = 16'h1F41;
    goto_line(8);
    for (int i = 0; i < 8; i++) begin
      step(i, 8);
      check($sformatf("small char_address h=%0d", i), 32'(sif.char_address), 32'(40 + i / 4));
      if (i >= 2)
        check($sformatf("small font_address h=%0d", i - 2), 32'(sif.font_address),
              (32'h41 << 2) | 32'((i - 2) % 4));
    end

    // Cursor blink at cell (3,2); background-only glyph so a swap shows fg.
    reset_n = 1'b0;
    #5;
    reset_n = 1'b1;
    tword     = 16'h1F41;
    fbits     = 14'h0000;
    cursor_en = 1'b1;
    pix_check("cursor phase0", 40, 24, 8'h02);
    frames(29);
    pix_check("cursor 29 frames", 40, 24, 8'h02);
    frames(1);
    pix_check("cursor row12", 40, 24, 8'hDB);
    pix_check("cursor row13", 41, 31, 8'hDB);
    pix_check("cursor left of cell", 40, 23, 8'h02);
    pix_check("cursor right of cell", 40, 32, 8'h02);
    pix_check("cursor row11", 39, 24, 8'h02);
    cursor_en = 1'b0;
    pix_check("cursor disabled", 41, 24, 8'h02);
    cursor_en = 1'b1;
    frames(30);
    pix_check("cursor phase back", 40, 24, 8'h02);
    cursor_en = 1'b0;

    // Asynchronous reset in the middle of line 200.
    fbits = 14'h3FFF;
    goto_line(200);
    for (int k = 0; k < 5; k++) step(8, 200);
    check("pre-reset char_address", 32'(mif.char_address), 32'(14 * 80 + 1));
    check("pre-reset color", 32'(color), 32'h0000_00DB);
    #5;
    reset_n = 1'b0;
    #2;
    check("async reset color", 32'(color), 0);
    check("async reset char_address", 32'(mif.char_address), 0);
    check("async reset font_address", 32'(mif.font_address), 0);
    @(negedge clk);
    reset_n = 1'b1;
    step(16, 200);
    check("post-reset restarted rows", 32'(mif.char_address), 2);
    goto_line(0);
    step(8, 0);
    check("post-clear line0 h8", 32'(mif.char_address), 1);
    goto_line(14);
    step(0, 14);
    check("post-clear line14 h0", 32'(mif.char_address), 80);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
